// File: rtl/mips_seq_alu.sv
// Registered MIPS EX-stage ALU with iterative multiply/divide and HI/LO.
// Single-cycle ops complete in one edge; MUL/DIV take WIDTH iterations.
module mips_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] alu_res,
  output logic             zero,
  output logic             ovf,
  output logic             cout,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2  = 2 * WIDTH;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opnd, a_cap;
  logic             neg_q, neg_r, dz, dovf;

  logic             accept, last, op_mul, op_div;
  logic             is_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign ready     = (state == IDLE);
  assign busy      = ~ready;
  assign accept    = start & ready;
  assign last      = (cnt == CNT_W'(1));
  assign op_mul    = (alu_ctl == 4'd8) | (alu_ctl == 4'd9);
  assign op_div    = (alu_ctl == 4'd10) | (alu_ctl == 4'd11);
  assign is_signed = ~alu_ctl[0];
  assign sa        = is_signed & a[MSB];
  assign sb        = is_signed & b[MSB];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b : b;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && op_mul) state_nx = MUL;
        if (accept && op_div) state_nx = DIV;
      end
      MUL, DIV: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // single-cycle datapath
  logic [WIDTH-1:0] bx, res_c;
  logic             cx, cout_c, ovf_c;
  logic [WIDTH:0]   sum;

  always_comb begin
    bx     = (alu_ctl == 4'd5) ? ~b : b;
    cx     = (alu_ctl == 4'd5) ? 1'b1 : cin;
    sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};
    res_c  = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    case (alu_ctl)
      4'd0: res_c = a & b;
      4'd1: res_c = a | b;
      4'd2: res_c = a ^ b;
      4'd3: res_c = ~(a | b);
      4'd4: begin
        res_c  = sum[MSB:0];
        cout_c = sum[WIDTH];
        ovf_c  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd5: begin
        res_c  = sum[MSB:0];
        cout_c = sum[WIDTH];
        ovf_c  = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd6: res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd7: res_c = {{(WIDTH-1){1'b0}}, a < b};
      4'd12: res_c = hi;
      4'd13: res_c = lo;
      4'd14, 4'd15: res_c = a;
      default: res_c = '0;
    endcase
  end

  // shift-add step: acc = {partial, multiplier}
  logic [WIDTH:0]   madd;
  logic [W2-1:0]    mul_nx, prod_s;

  assign madd   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nx = {madd, acc[WIDTH-1:1]};
  assign prod_s = neg_q ? -mul_nx : mul_nx;

  // restoring step: acc = {remainder, quotient}
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n, q_s, r_s;

  assign sh    = {acc[W2-1:WIDTH], acc[MSB]};
  assign ge    = sh >= {1'b0, opnd};
  assign rem_n = ge ? (sh[MSB:0] - opnd) : sh[MSB:0];
  assign quo_n = {acc[MSB-1:0], ge};
  assign q_s   = neg_q ? -quo_n : quo_n;
  assign r_s   = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_cap   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      dovf    <= 1'b0;
      valid   <= 1'b0;
      alu_res <= '0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
      cout    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nx;
      valid <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          if (op_mul) begin
            cnt   <= CNT_W'(WIDTH);
            acc   <= {{WIDTH{1'b0}}, mag_b};
            opnd  <= mag_a;
            neg_q <= sa ^ sb;
          end else if (op_div) begin
            cnt   <= CNT_W'(WIDTH);
            acc   <= {{WIDTH{1'b0}}, mag_a};
            opnd  <= mag_b;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            a_cap <= a;
            dz    <= (b == '0);
            dovf  <= is_signed && (a == {1'b1, {MSB{1'b0}}}) && (b == '1);
          end else begin
            valid   <= 1'b1;
            alu_res <= res_c;
            zero    <= ~|res_c;
            ovf     <= ovf_c;
            cout    <= cout_c;
            if (alu_ctl == 4'd14) hi <= a;
            if (alu_ctl == 4'd15) lo <= a;
          end
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          acc <= mul_nx;
          if (last) begin
            valid   <= 1'b1;
            hi      <= prod_s[W2-1:WIDTH];
            lo      <= prod_s[MSB:0];
            alu_res <= prod_s[MSB:0];
            zero    <= ~|prod_s[MSB:0];
            ovf     <= 1'b0;
            cout    <= 1'b0;
          end
        end
        DIV: begin
          cnt <= cnt - 1'b1;
          acc <= {rem_n, quo_n};
          if (last) begin
            valid <= 1'b1;
            cout  <= 1'b0;
            div0  <= dz;
            if (dz) begin
              hi      <= a_cap;
              lo      <= '1;
              alu_res <= '1;
              zero    <= 1'b0;
              ovf     <= 1'b0;
            end else begin
              hi      <= r_s;
              lo      <= q_s;
              alu_res <= q_s;
              zero    <= ~|q_s;
              ovf     <= dovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
